instr_encoder: RTL and testbench

Instruction encoder and program writer: the write-side counterpart of the instruction decoder. It accepts instruction fields over a valid/ready handshake and packs them into the 17-bit instruction word the decoder consumes. Encoded words are buffered in a small FIFO and written into instruction memory at auto-incrementing addresses. It sits between the program loader/debug port and the instruction memory.

---
 rtl/instr_encoder.sv | 174 +++++++++++++++++
 tb/tb_instr_encoder.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Instruction encoder and program writer.
// Packs R-type / I-type field bundles into 17-bit instruction words, queues them
// in a small FIFO and streams them into instruction memory at auto-incrementing
// addresses. Out-of-range I-type immediates are dropped and flagged.
//
// Drain FSM states:
//   state    | meaning
//   ---------+-----------------------------------------------
//   S_IDLE   | FIFO empty, nothing to write
//   S_ACTIVE | FIFO holds words, memory accepted writes last cycle
//   S_STALL  | FIFO holds words, memory was busy last cycle
module instr_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              fmt,
    input  logic [4:0]        opcode,
    input  logic [2:0]        dr,
    input  logic [2:0]        sa,
    input  logic [2:0]        sb,
    input  logic [2:0]        sh,
    input  logic [7:0]        imm,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              load_addr,
    input  logic              clr_flags,
    input  logic              mem_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [16:0]       mem_wdata,
    output logic              busy,
    output logic              err_range,
    output logic              wrapped,
    output logic [ADDR_W:0]   words_written
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int WW_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_STALL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [16:0]       fifo_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WW_W-1:0]   words_q, words_d;
    logic              err_q, err_d;
    logic              wrap_q, wrap_d;

    logic              empty;
    logic              full;
    logic              accept;
    logic              imm_ok;
    logic              bundle_ok;
    logic              push;
    logic              pop;
    logic              err_set;
    logic              wrap_set;
    logic [16:0]       enc_word;

    // An 8-bit signed value fits in 6-bit signed when its top three bits agree.
    assign imm_ok    = (imm[7:5] == 3'b000) || (imm[7:5] == 3'b111);
    assign bundle_ok = !fmt || imm_ok;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && bundle_ok;
    assign err_set  = accept && !bundle_ok;
    assign pop      = !empty && !mem_busy;

    assign enc_word = fmt ? {opcode, dr, sa, imm[5:0]}
                          : {opcode, dr, sa, sb, sh};

    assign mem_we        = pop;
    assign mem_addr      = addr_q;
    assign mem_wdata     = empty ? 17'd0 : fifo_q[rd_ptr_q];
    assign busy          = (state_q != S_IDLE);
    assign err_range     = err_q;
    assign wrapped       = wrap_q;
    assign words_written = words_q;

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Write address, commit counter and sticky flags next-state.
    always_comb begin
        addr_d   = addr_q;
        words_d  = words_q;
        wrap_set = 1'b0;
        if (pop) begin
            addr_d   = addr_q + ADDR_W'(1);
            words_d  = words_q + WW_W'(1);
            wrap_set = &addr_q;
        end else if (empty && load_addr) begin
            // A preload only lands while nothing is queued, so it never
            // reorders words already waiting for memory.
            addr_d = start_addr;
        end
        // A setting event on the same edge as a clear keeps the flag high.
        err_d  = err_set  || (err_q  && !clr_flags);
        wrap_d = wrap_set || (wrap_q && !clr_flags);
    end

    // Drain FSM next-state, tracking the occupancy that will exist after this edge.
    always_comb begin
        state_d = state_q;
        if (count_d == '0) begin
            state_d = S_IDLE;
        end else if (mem_busy) begin
            state_d = S_STALL;
        end else begin
            state_d = S_ACTIVE;
        end
    end

    // Control state with asynchronous clear; queued words vanish with count_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            words_q  <= '0;
            err_q    <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            words_q  <= words_d;
            err_q    <= err_d;
            wrap_q   <= wrap_d;
        end
    end

    // FIFO storage; contents are only observable while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= enc_word;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed table, corner sequences and random
// traffic checked against a queue-based reference model.
module tb_instr_encoder;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              fmt;
    logic [4:0]        opcode;
    logic [2:0]        dr, sa, sb, sh;
    logic [7:0]        imm;
    logic [ADDR_W-1:0] start_addr;
    logic              load_addr;
    logic              clr_flags;
    logic              mem_busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [16:0]       mem_wdata;
    logic              busy;
    logic              err_range;
    logic              wrapped;
    logic [ADDR_W:0]   words_written;

    int total = 0;
    int bad   = 0;

    // reference model state
    int mq[$];
    int m_addr;
    int m_ww;
    int m_err;
    int m_wrap;

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .dr(dr), .sa(sa), .sb(sb), .sh(sh), .imm(imm),
        .start_addr(start_addr), .load_addr(load_addr), .clr_flags(clr_flags),
        .mem_busy(mem_busy), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .err_range(err_range),
        .wrapped(wrapped), .words_written(words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        fmt;
        logic [4:0]  opcode;
        logic [2:0]  dr, sa, sb, sh;
        logic [7:0]  imm;
        logic        exp_push;
        logic [16:0] exp_word;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int signed_imm(input logic [7:0] v);
        int u;
        u = int'(v);
        return (u > 127) ? u - 256 : u;
    endfunction

    function automatic int encode(input logic f, input logic [4:0] op, input logic [2:0] d,
                                  input logic [2:0] a, input logic [2:0] b, input logic [2:0] s,
                                  input logic [7:0] im);
        int low;
        low = f ? (int'(im) % 64) : (int'(b) * 8 + int'(s));
        return int'(op) * 4096 + int'(d) * 512 + int'(a) * 64 + low;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_addr = 0;
        m_ww   = 0;
        m_err  = 0;
        m_wrap = 0;
    endtask

    // Compare all outputs against the model mid-cycle, then advance the model
    // across the next rising edge.
    task automatic cycle();
        int  n;
        int  si;
        bit  acc, ok, we, was_empty, wset;
        @(negedge clk);
        n = mq.size();
        chk("in_ready", in_ready, (n < DEPTH) ? 1 : 0);
        chk("mem_we", mem_we, (n > 0 && !mem_busy) ? 1 : 0);
        chk("mem_wdata", mem_wdata, (n > 0) ? mq[0] : 0);
        chk("mem_addr", mem_addr, m_addr);
        chk("busy", busy, (n > 0) ? 1 : 0);
        chk("err_range", err_range, m_err);
        chk("wrapped", wrapped, m_wrap);
        chk("words_written", words_written, m_ww);

        si        = signed_imm(imm);
        acc       = in_valid && (n < DEPTH);
        ok        = !fmt || (si >= -32 && si <= 31);
        we        = (n > 0) && !mem_busy;
        was_empty = (n == 0);
        wset      = 0;
        if (we) begin
            void'(mq.pop_front());
            if (m_addr == (1 << ADDR_W) - 1) begin
                m_addr = 0;
                wset   = 1;
            end else begin
                m_addr = m_addr + 1;
            end
            m_ww = (m_ww + 1) % (1 << (ADDR_W + 1));
        end
        if (was_empty && load_addr) m_addr = int'(start_addr);
        if (acc && ok) mq.push_back(encode(fmt, opcode, dr, sa, sb, sh, imm));
        if (acc && !ok)      m_err = 1;
        else if (clr_flags)  m_err = 0;
        if (wset)            m_wrap = 1;
        else if (clr_flags)  m_wrap = 0;

        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = 0;
        fmt        = 0;
        opcode     = '0;
        dr         = '0;
        sa         = '0;
        sb         = '0;
        sh         = '0;
        imm        = '0;
        start_addr = '0;
        load_addr  = 0;
        clr_flags  = 0;
        mem_busy   = 0;
    endtask

    task automatic drive_r(input logic [4:0] op, input logic [2:0] d, input logic [2:0] a,
                           input logic [2:0] b, input logic [2:0] s);
        in_valid = 1; fmt = 0; opcode = op; dr = d; sa = a; sb = b; sh = s; imm = '0;
    endtask

    task automatic drive_i(input logic [4:0] op, input logic [2:0] d, input logic [2:0] a,
                           input logic [7:0] im);
        in_valid = 1; fmt = 1; opcode = op; dr = d; sa = a; sb = '0; sh = '0; imm = im;
    endtask

    initial begin
        vecs[0] = '{1'b0, 5'b01111, 3'b010, 3'b110, 3'b001, 3'b000, 8'h00, 1'b1, 17'h0F588};
        vecs[1] = '{1'b1, 5'b10100, 3'b100, 3'b010, 3'b000, 3'b000, 8'h10, 1'b1, 17'h14890};
        vecs[2] = '{1'b1, 5'b00011, 3'b001, 3'b001, 3'b000, 3'b000, 8'hDF, 1'b0, 17'h00000};
        vecs[3] = '{1'b1, 5'b00001, 3'b001, 3'b001, 3'b000, 3'b000, 8'h1F, 1'b1, 17'h0125F};
        vecs[4] = '{1'b1, 5'b11111, 3'b111, 3'b000, 3'b000, 3'b000, 8'hE0, 1'b1, 17'h1FE20};
        vecs[5] = '{1'b1, 5'b00010, 3'b000, 3'b000, 3'b000, 3'b000, 8'h20, 1'b0, 17'h00000};
        vecs[6] = '{1'b0, 5'b10101, 3'b011, 3'b100, 3'b101, 3'b111, 8'hFF, 1'b1, 17'h1572F};
        vecs[7] = '{1'b1, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 8'hFF, 1'b1, 17'h0003F};
        vecs[8] = '{1'b1, 5'b01010, 3'b010, 3'b010, 3'b000, 3'b000, 8'h80, 1'b0, 17'h00000};
        vecs[9] = '{1'b1, 5'b01010, 3'b010, 3'b010, 3'b000, 3'b000, 8'h7F, 1'b0, 17'h00000};

        idle_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;

        // reset values
        #3;
        chk("rst in_ready", in_ready, 1);
        chk("rst mem_we", mem_we, 0);
        chk("rst busy", busy, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst words_written", words_written, 0);
        chk("rst err_range", err_range, 0);
        chk("rst wrapped", wrapped, 0);
        cycle();

        // table of single bundles, each written the cycle after acceptance
        for (int i = 0; i < NV; i++) begin
            in_valid = 1;
            fmt = vecs[i].fmt; opcode = vecs[i].opcode; dr = vecs[i].dr; sa = vecs[i].sa;
            sb = vecs[i].sb; sh = vecs[i].sh; imm = vecs[i].imm;
            cycle();
            in_valid = 0;
            #3;
            if (vecs[i].exp_push) begin
                chk($sformatf("vec%0d mem_we", i), mem_we, 1);
                chk($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].exp_word);
                cycle();
            end else begin
                chk($sformatf("vec%0d mem_we", i), mem_we, 0);
                chk($sformatf("vec%0d err_range", i), err_range, 1);
                clr_flags = 1;
                cycle();
                clr_flags = 0;
                #3;
                chk($sformatf("vec%0d err cleared", i), err_range, 0);
            end
        end
        if (words_written !== 9'(NV - 4)) begin
            chk("table words_written", words_written, NV - 4);
        end else begin
            chk("table words_written", words_written, 6);
        end

        // preload address together with the first push
        drive_i(5'b10100, 3'b100, 3'b010, 8'h10);
        load_addr = 1; start_addr = 8'h20;
        cycle();
        in_valid = 0; load_addr = 0;
        #3;
        chk("load mem_addr", mem_addr, 8'h20);
        chk("load mem_wdata", mem_wdata, 17'h14890);
        chk("load mem_we", mem_we, 1);
        cycle();

        // error event and clear on the same edge: the flag stays set
        drive_i(5'b00001, 3'b000, 3'b000, 8'hDF);
        clr_flags = 1;
        cycle();
        in_valid = 0; clr_flags = 0;
        #3;
        chk("err beats clr", err_range, 1);
        clr_flags = 1;
        cycle();
        clr_flags = 0;

        // fill under backpressure, then drain in order
        mem_busy = 1;
        for (int k = 0; k < 4; k++) begin
            drive_r(5'(k + 1), 3'b000, 3'b000, 3'b000, 3'b000);
            cycle();
        end
        drive_r(5'b11111, 3'b111, 3'b111, 3'b111, 3'b111);
        #3;
        chk("full in_ready", in_ready, 0);
        chk("full mem_we", mem_we, 0);
        cycle();
        in_valid = 0;
        mem_busy = 0;
        for (int k = 0; k < 4; k++) begin
            #3;
            chk($sformatf("drain%0d mem_we", k), mem_we, 1);
            chk($sformatf("drain%0d mem_wdata", k), mem_wdata, (k + 1) * 4096);
            if (k == 0) chk("drain0 in_ready", in_ready, 0);
            if (k == 1) chk("drain1 in_ready", in_ready, 1);
            cycle();
        end
        #3;
        chk("drained busy", busy, 0);

        // address wrap
        drive_r(5'b00101, 3'b001, 3'b010, 3'b011, 3'b100);
        load_addr = 1; start_addr = 8'hFF;
        cycle();
        load_addr = 0;
        drive_r(5'b01001, 3'b110, 3'b101, 3'b100, 3'b011);
        #3;
        chk("wrap first addr", mem_addr, 8'hFF);
        chk("wrap first we", mem_we, 1);
        cycle();
        in_valid = 0;
        #3;
        chk("wrap second addr", mem_addr, 8'h00);
        chk("wrap flag", wrapped, 1);
        chk("wrap second word", mem_wdata, encode(0, 5'b01001, 3'b110, 3'b101, 3'b100, 3'b011, 8'h00));
        cycle();
        clr_flags = 1;
        cycle();
        clr_flags = 0;

        // random traffic
        for (int c = 0; c < 600; c++) begin
            int busy_pct;
            busy_pct  = ((c / 50) % 2 == 0) ? 20 : 75;
            in_valid  = ($urandom_range(0, 99) < 70);
            fmt       = $urandom_range(0, 1);
            opcode    = 5'($urandom);
            dr        = 3'($urandom);
            sa        = 3'($urandom);
            sb        = 3'($urandom);
            sh        = 3'($urandom);
            if ($urandom_range(0, 3) == 0) imm = 8'($urandom);
            else                           imm = 8'($urandom_range(0, 63) - 32);
            load_addr  = ($urandom_range(0, 7) == 0);
            start_addr = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
            clr_flags  = ($urandom_range(0, 9) == 0);
            mem_busy   = ($urandom_range(0, 99) < busy_pct);
            cycle();
        end
        idle_inputs();

        // reset with words queued
        mem_busy = 1;
        for (int k = 0; k < 3; k++) begin
            drive_r(5'(k + 7), 3'b001, 3'b001, 3'b001, 3'b001);
            cycle();
        end
        in_valid = 0;
        load_addr = 1; start_addr = 8'h55;
        cycle();
        load_addr = 0;
        for (int k = 0; k < 2; k++) begin
            drive_r(5'(k + 3), 3'b010, 3'b010, 3'b010, 3'b010);
            cycle();
        end
        in_valid = 0;
        #3;
        chk("pre-reset busy", busy, 1);
        mem_busy = 0;
        rst_n = 0;
        #1;
        chk("async rst busy", busy, 0);
        chk("async rst mem_we", mem_we, 0);
        chk("async rst in_ready", in_ready, 1);
        model_reset();
        @(posedge clk);
        #1;
        chk("held rst mem_we", mem_we, 0);
        rst_n = 1;
        #3;
        chk("post rst mem_addr", mem_addr, 0);
        chk("post rst words_written", words_written, 0);
        chk("post rst mem_we", mem_we, 0);
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
